// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int STALL_CNT_W = 16;
   localparam int BURST_DEF = 4;
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: cyclic first-set search over a request vector, starting just after last
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic                    found,
   output logic [$clog2(NREQ)-1:0] idx
);
   localparam int IW = $clog2(NREQ);
   // scan from the far end so the nearest set bit after last wins
   always_comb begin
      idx = '0;
      for (int i = NREQ; i >= 1; i--) begin
         if (req[(int'(last) + i) % NREQ]) idx = IW'((int'(last) + i) % NREQ);
      end
   end
   assign found = |req;
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter feeding one FIFO write port.
// Define FIFO_ARB_STALL_CNT_EN to build the saturating full-stall counter.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int NREQ = 4,
   parameter int BURST = BURST_DEF
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [NREQ-1:0]          req_valid_i,
   input  logic [NREQ*DWIDTH-1:0]   req_data_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic                     fifo_full_i,
   output logic                     fifo_wr_o,
   output logic [DWIDTH-1:0]        fifo_wrdata_o,
   output logic                     grant_valid_o,
   output logic [$clog2(NREQ)-1:0]  grant_o,
   output logic [STALL_CNT_W-1:0]   stall_cnt_o
);
   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(BURST + 1);
   state_t          state;
   logic [IW-1:0]   grant_q, last_q, pick_idx;
   logic [BW-1:0]   beat_cnt;
   logic            pick_found, cur_valid, beat, rel;
   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_valid_i),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );
   assign cur_valid     = req_valid_i[grant_q];
   assign beat          = state == GRANT && cur_valid && !fifo_full_i;
   assign rel           = !cur_valid || (beat && beat_cnt == BW'(BURST - 1));
   assign req_ready_o   = (state == GRANT && !fifo_full_i) ? NREQ'(1) << grant_q : '0;
   assign fifo_wr_o     = beat;
   assign fifo_wrdata_o = state == GRANT ? req_data_i[grant_q*DWIDTH +: DWIDTH] : '0;
   assign grant_valid_o = state == GRANT;
   assign grant_o       = grant_q;
   // last_q == grant_q while granted, so a pick equal to grant_q means nobody else is asking
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= IDLE;
         grant_q  <= '0;
         last_q   <= IW'(NREQ - 1);
         beat_cnt <= '0;
      end else if (state == IDLE || rel) begin
         state <= pick_found ? GRANT : IDLE;
         if (pick_found) begin
            grant_q  <= pick_idx;
            last_q   <= pick_idx;
            beat_cnt <= '0;
         end
      end else if (beat) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end
`ifdef FIFO_ARB_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_q;
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) stall_q <= '0;
      else if (state == GRANT && cur_valid && fifo_full_i && stall_q != '1) stall_q <= stall_q + 1'b1;
   end
   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed bench with expected-write queue and an independent write monitor
module tb_fifo_wr_arb;
   localparam int NREQ = 4;
   localparam int DW = 8;
`ifdef FIFO_ARB_STALL_CNT_EN
   localparam int STALL_EXP = 3;
`else
   localparam int STALL_EXP = 0;
`endif
   logic              clk_i = 0, rstn_i = 0, fifo_full_i = 0;
   logic [NREQ-1:0]   req_valid_i = '0, req_ready_o;
   logic [NREQ*DW-1:0] req_data_i = '0;
   logic              fifo_wr_o, grant_valid_o;
   logic [DW-1:0]     fifo_wrdata_o;
   logic [1:0]        grant_o;
   logic [15:0]       stall_cnt_o;
   fifo_wr_arb #(.DWIDTH(DW), .NREQ(NREQ), .BURST(4)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .fifo_full_i(fifo_full_i), .fifo_wr_o(fifo_wr_o),
      .fifo_wrdata_o(fifo_wrdata_o), .grant_valid_o(grant_valid_o), .grant_o(grant_o),
      .stall_cnt_o(stall_cnt_o)
   );
   always #5 clk_i = ~clk_i;

   int errors = 0, checks = 0;
   logic [7:0]  mem [NREQ][16];
   int          head [NREQ];
   int          cnt [NREQ];
   logic [NREQ-1:0] en = '0, acc;
   logic [15:0] exp_q [$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // expected write: requester k, word j carries data k*16+j
   task automatic expect_wr(int k, int j);
      exp_q.push_back({8'(k), 8'(k * 16 + j)});
   endtask

   task automatic load(int k, int n);
      for (int j = 0; j < n; j++) begin
         mem[k][(head[k] + cnt[k]) % 16] = 8'(k * 16 + j);
         cnt[k]++;
      end
   endtask

   task automatic clear();
      for (int k = 0; k < NREQ; k++) begin
         head[k] = 0;
         cnt[k] = 0;
      end
   endtask

   task automatic apply();
      for (int k = 0; k < NREQ; k++) begin
         req_valid_i[k] = en[k] && cnt[k] != 0;
         req_data_i[k*DW +: DW] = cnt[k] != 0 ? mem[k][head[k]] : 8'h00;
      end
      #1;
   endtask

   task automatic cycle();
      @(negedge clk_i);
      acc = req_ready_o & req_valid_i;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < NREQ; k++) begin
         if (acc[k]) begin
            head[k] = (head[k] + 1) % 16;
            cnt[k]--;
         end
      end
      apply();
   endtask

   task automatic drain(int bound);
      while (exp_q.size() != 0 && bound > 0) begin
         cycle();
         bound--;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rstn_i = 0;
      clear();
      en = '0;
      fifo_full_i = 0;
      apply();
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1;
      #1;
   endtask

   always @(negedge clk_i) begin
      if (rstn_i && fifo_full_i) begin
         chk("full_ready", req_ready_o, 0);
         chk("full_wr", fifo_wr_o, 0);
      end
      if (rstn_i && fifo_wr_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr: got grant %0d data %0h expected no write", grant_o, fifo_wrdata_o);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk("wr_data", fifo_wrdata_o, e[7:0]);
            chk("wr_grant", grant_o, e[15:8]);
         end
      end
   end

   initial begin
      clear();
      apply();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_grant_valid", grant_valid_o, 0);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_wr", fifo_wr_o, 0);
      chk("rst_wrdata", fifo_wrdata_o, 0);
      chk("rst_grant", grant_o, 0);
      chk("rst_stall", stall_cnt_o, 0);
      rstn_i = 1;
      #1;
      // single requester, 6 words: burst of 4 then seamless re-grant for 2
      load(0, 6);
      en = 4'b0001;
      apply();
      for (int j = 0; j < 6; j++) expect_wr(0, j);
      chk("a_idle_latency", grant_valid_o, 0);
      cycle();
      chk("a_grant_valid", grant_valid_o, 1);
      chk("a_grant", grant_o, 0);
      for (int j = 0; j < 6; j++) begin
         chk("a_back_to_back", fifo_wr_o, 1);
         cycle();
      end
      chk("a_no_extra", fifo_wr_o, 0);
      drain(4);
      repeat (2) cycle();
      chk("a_idle_after", grant_valid_o, 0);
      // all four valid: order 0,1,2,3,0 with four beats each and no bubble
      do_reset();
      load(0, 8);
      for (int k = 1; k < 4; k++) load(k, 4);
      for (int j = 0; j < 4; j++) expect_wr(0, j);
      for (int k = 1; k < 4; k++) for (int j = 0; j < 4; j++) expect_wr(k, j);
      for (int j = 4; j < 8; j++) expect_wr(0, j);
      en = 4'b1111;
      apply();
      cycle();
      for (int i = 0; i < 20; i++) begin
         chk("b_no_bubble", fifo_wr_o, 1);
         cycle();
      end
      drain(4);
      cycle();
      chk("b_idle_after", grant_valid_o, 0);
      // requester 2 stalls on full for 3 cycles mid-burst; requester 3 waits its turn
      do_reset();
      load(2, 4);
      load(3, 1);
      for (int j = 0; j < 4; j++) expect_wr(2, j);
      expect_wr(3, 0);
      en = 4'b1100;
      apply();
      cycle();
      chk("c_grant", grant_o, 2);
      cycle();
      fifo_full_i = 1;
      apply();
      for (int i = 0; i < 3; i++) begin
         chk("c_stall_ready", req_ready_o, 0);
         chk("c_stall_grant", grant_o, 2);
         cycle();
      end
      fifo_full_i = 0;
      apply();
      chk("c_stall_cnt", stall_cnt_o, STALL_EXP);
      chk("c_resume_ready", req_ready_o, 4'b0100);
      drain(10);
      // requester 1 drops valid after 2 beats, requester 3 takes over
      do_reset();
      load(1, 2);
      load(3, 2);
      expect_wr(1, 0);
      expect_wr(1, 1);
      expect_wr(3, 0);
      expect_wr(3, 1);
      en = 4'b1010;
      apply();
      cycle();
      chk("d_grant1", grant_o, 1);
      repeat (3) cycle();
      chk("d_grant3", grant_o, 3);
      chk("d_grant3_valid", grant_valid_o, 1);
      chk("d_ready3", req_ready_o, 4'b1000);
      drain(6);
      // reset mid-burst of requester 3, then requester 0 wins first
      do_reset();
      load(3, 4);
      expect_wr(3, 0);
      expect_wr(3, 1);
      en = 4'b1000;
      apply();
      repeat (3) cycle();
      chk("e_pre_grant", grant_o, 3);
      rstn_i = 0;
      #1;
      chk("e_rst_ready", req_ready_o, 0);
      chk("e_rst_wr", fifo_wr_o, 0);
      chk("e_rst_wrdata", fifo_wrdata_o, 0);
      chk("e_rst_gv", grant_valid_o, 0);
      chk("e_rst_grant", grant_o, 0);
      chk("e_rst_sent", exp_q.size(), 0);
      clear();
      for (int k = 0; k < 4; k++) begin
         load(k, 1);
         expect_wr(k, 0);
      end
      en = 4'b1111;
      apply();
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1;
      #1;
      cycle();
      chk("e_first_grant", grant_o, 0);
      drain(12);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DWIDTH, default 8, width of each requester's data word and of the FIFO write data.
REQ-002 Parameter NREQ, default 4, number of requesters, range 2..8.
REQ-003 Parameter BURST, default 4, maximum consecutive beats per grant, range 1..16.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 req_valid_i  input  NREQ  per-requester write request.
REQ-007 req_data_i  input  NREQ*DWIDTH  flattened data; requester k occupies bits [k*DWIDTH +: DWIDTH].
REQ-008 req_ready_o  output  NREQ  per-requester accept strobe.
REQ-009 fifo_full_i  input  1  full flag of the downstream FIFO.
REQ-010 fifo_wr_o  output  1  FIFO write strobe.
REQ-011 fifo_wrdata_o  output  DWIDTH  FIFO write data.
REQ-012 grant_valid_o  output  1  a requester currently holds the grant.
REQ-013 grant_o  output  $clog2(NREQ)  index of the granted requester.
REQ-014 stall_cnt_o  output  16  count of full-stalled cycles (see Configuration).

Function
REQ-015 States: IDLE (no grant) and GRANT (grant_q valid); state, grant_q, last_q and beat_cnt are registers.
REQ-016 Winner: first k with req_valid_i[k]=1, searching cyclically from last_q+1.
REQ-017 IDLE: if any req_valid_i, the next edge loads grant_q=winner, last_q=winner, beat_cnt=0, state=GRANT; one-cycle arbitration latency.
REQ-018 GRANT: req_ready_o[grant_q]=~fifo_full_i; all other req_ready_o bits 0.
REQ-019 Beat = req_valid_i[grant_q] & ~fifo_full_i; fifo_wr_o = beat, combinational.
REQ-020 fifo_wrdata_o = req_data_i slice of grant_q, combinational in GRANT; 0 in IDLE.
REQ-021 On each beat, beat_cnt increments by 1.
REQ-022 Release occurs on a beat with beat_cnt==BURST-1, or in any cycle where req_valid_i[grant_q]=0.
REQ-023 On release, if any requester other than grant_q is valid, the next edge loads that winner with beat_cnt=0 and state stays GRANT (no bubble).
REQ-024 On release with no other requester valid: next state IDLE, unless req_valid_i[grant_q]=1, in which case grant_q is re-granted with beat_cnt=0.
REQ-025 fifo_full_i high: no beat, beat_cnt held, grant held indefinitely, no timeout.
REQ-026 req_ready_o is never asserted while fifo_full_i=1; fifo_wr_o is never asserted while fifo_full_i=1.
REQ-027 grant_valid_o=(state==GRANT); grant_o=grant_q.

Reset
REQ-028 rstn_i low asynchronously forces: state=IDLE, grant_q=0, last_q=NREQ-1 (requester 0 wins first), beat_cnt=0, stall counter=0.
REQ-029 While in reset, all outputs are 0.
REQ-030 Reset mid-burst discards the burst; the first post-reset arbitration follows REQ-017.

Configuration
REQ-031 Macro FIFO_ARB_STALL_CNT_EN defined: stall_cnt_o increments each cycle with grant_valid_o=1, req_valid_i[grant_q]=1 and fifo_full_i=1, saturating at 16'hFFFF.
REQ-032 Macro undefined: no counter logic is built and stall_cnt_o is tied to 0.

Structure
REQ-033 Package fifo_arb_pkg holds the state enum (IDLE, GRANT), the STALL_CNT_W=16 constant and the default BURST value.
REQ-034 The cyclic winner search is a combinational sub-module rr_pick (inputs: request vector, last index; outputs: found, index), instantiated once.

Verification
REQ-035 Reset, then req_valid_i=4'b0001 with 6 words queued, full=0 -> grant_o=0 one cycle later; beats 4, 1-cycle re-grant, beats 2; fifo_wr_o pulses total 6.
REQ-036 req_valid_i=4'b1111 held, full=0 -> grant order 0,1,2,3,0; each holds exactly 4 beats; no idle cycle between grants.
REQ-037 Requester 2 granted; full=1 for 3 cycles mid-burst -> req_ready_o=0 and fifo_wr_o=0 for 3 cycles, beat_cnt held, grant unchanged; with macro defined, stall_cnt_o +3.
REQ-038 Requester 1 granted; valid drops after 2 beats while requester 3 is valid -> next edge grant_o=3 with beat_cnt=0.
REQ-039 rstn_i pulsed low mid-burst of requester 3 -> outputs 0 immediately; after release, requester 0 is favoured when all are valid.
REQ-040 Scoreboard on every run: FIFO write sequence equals per-requester accepted data in order; no write is issued while full.
